// File: rtl/fir_driver_if.sv
// -----------------------------------------------------------------------------
// fir_driver_if
//   Host-side valid/ready word port of fir_driver.
//
//   in_data      host word (sample, or coefficient in the low TAP_SIZE bits)
//   in_is_coeff  1 = coefficient word, 0 = sample word
//   in_valid     host word valid
//   in_ready     driver can accept; a transfer happens on in_valid & in_ready
//
//   master : the host (drives data/valid, observes ready)
//   slave  : fir_driver (observes data/valid, drives ready)
// -----------------------------------------------------------------------------
interface fir_driver_if #(
  parameter int X_N_SIZE = 8
);
  logic [X_N_SIZE-1:0] in_data;
  logic                in_is_coeff;
  logic                in_valid;
  logic                in_ready;

  modport master (
    output in_data,
    output in_is_coeff,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_is_coeff,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/fir_driver.sv
// -----------------------------------------------------------------------------
// fir_driver
//   Host-side sequencer for fir_main. Buffers host samples in a small FIFO,
//   shadows a full coefficient set, and drives x_n / s_axis_fir_tvalid /
//   s_set_coeffs with the slot timing fir_main samples on. The FIR result is
//   captured once per sample slot and returned with a one-cycle y_valid pulse.
//
//   Ports
//     clk, reset           single rising-edge clock, async active-high reset
//     host (slave)         valid/ready host word port (see fir_driver_if)
//     run                  streaming enable
//     x_n                  sample / coefficient word to the FIR (registered)
//     s_axis_fir_tvalid    sample-stream valid to the FIR (registered)
//     s_set_coeffs         coefficient-load strobe to the FIR (registered)
//     fir_y_n              FIR result (o_y_n)
//     y_out, y_valid       captured result and its one-cycle pulse
//     underrun             sticky: a slot fired with the FIFO empty
//
//   Build option
//     FIR_DRV_UNDERRUN_HOLD_EN  defined: an underrun slot repeats the last
//                               sample driven (0 if none since reset).
//                               undefined: an underrun slot drives 0.
// -----------------------------------------------------------------------------
module fir_driver #(
  parameter int X_N_SIZE     = 8,
  parameter int TAP_SIZE     = 3,
  parameter int NBR_OF_TAPS  = 3,
  parameter int Y_N_SIZE     = 11,
  parameter int SLOT_LEN     = 6,
  parameter int STARTUP_WAIT = 5,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                reset,
  fir_driver_if.slave         host,
  input  logic                run,
  output logic [X_N_SIZE-1:0] x_n,
  output logic                s_axis_fir_tvalid,
  output logic                s_set_coeffs,
  input  logic [Y_N_SIZE-1:0] fir_y_n,
  output logic [Y_N_SIZE-1:0] y_out,
  output logic                y_valid,
  output logic                underrun
);

  localparam int PTR_W  = (FIFO_DEPTH > 1)   ? $clog2(FIFO_DEPTH)   : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int TAP_W  = (NBR_OF_TAPS > 1)  ? $clog2(NBR_OF_TAPS)  : 1;
  localparam int STEP_W = $clog2(NBR_OF_TAPS + 1);
  localparam int PH_W   = (SLOT_LEN > 1)     ? $clog2(SLOT_LEN)     : 1;
  localparam int INIT_W = (STARTUP_WAIT > 1) ? $clog2(STARTUP_WAIT) : 1;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_CFG,
    S_START,
    S_STREAM
  } state_t;

  state_t              state;
  logic [INIT_W-1:0]   init_cnt;
  logic [PH_W-1:0]     phase;
  logic [STEP_W-1:0]   cfg_step;     // current CFG cycle index k of Ck
  logic                stopping;     // current p=0 is the stop slot
  logic                slot_seen;    // a sample slot preceded this p=0

  // Coefficient shadow
  logic [TAP_SIZE-1:0] shadow [NBR_OF_TAPS];
  logic [TAP_W-1:0]    coeff_cnt;
  logic                coeff_pending;
  logic [TAP_W-1:0]    cfg_idx;

  // Sample FIFO
  logic [X_N_SIZE-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    fifo_cnt;
  logic                fifo_full;
  logic                fifo_empty;
`ifdef FIR_DRV_UNDERRUN_HOLD_EN
  logic [X_N_SIZE-1:0] last_sample;
`endif

  // Handshake and slot decisions
  logic                in_ready_int;
  logic                push;
  logic                coeff_wr;
  logic                slot_edge;    // the next cycle is a p=0
  logic                stop_now;
  logic                pop;
  logic [X_N_SIZE-1:0] slot_x;

  assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);

  // Built from registered flags only, so a pop in the same cycle cannot
  // reopen a full FIFO: pop wins that slot and the host waits a cycle.
  assign in_ready_int  = (state != S_INIT) && !fifo_full && !coeff_pending;
  assign host.in_ready = in_ready_int;
  assign push          = host.in_valid && in_ready_int && !host.in_is_coeff;
  assign coeff_wr      = host.in_valid && in_ready_int &&  host.in_is_coeff;

  assign slot_edge = (state == S_START) ||
                     ((state == S_STREAM) && !stopping &&
                      (phase == PH_W'(SLOT_LEN - 1)));
  // A queued sample always goes out under the old taps; a pending load only
  // ends the stream once the FIFO has drained.
  assign stop_now  = !run || (fifo_empty && coeff_pending);
  assign pop       = slot_edge && !stop_now && !fifo_empty;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    slot_x  = '0;
    cfg_idx = TAP_W'(NBR_OF_TAPS - 1 - int'(cfg_step));
    if (!stop_now) begin
      if (!fifo_empty) begin
        slot_x = fifo_mem[rd_ptr];
      end
`ifdef FIR_DRV_UNDERRUN_HOLD_EN
      else begin
        slot_x = last_sample;
      end
`endif
    end
  end

  // NOTE: the storage array has no reset; the pointers and count alone say
  // which entries are valid, so reset only has to clear those.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= host.in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
`ifdef FIR_DRV_UNDERRUN_HOLD_EN
      last_sample <= '0;
`endif
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
`ifdef FIR_DRV_UNDERRUN_HOLD_EN
        last_sample <= fifo_mem[rd_ptr];
`endif
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Sequencer: state and all FIR-facing outputs are registered here, so the
  // value driven in a cycle is decided at the edge that enters it.
  // NOTE: sequential state uses non-blocking assignments only; later
  // assignments in the block intentionally override earlier defaults.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= S_INIT;
      init_cnt          <= '0;
      phase             <= '0;
      cfg_step          <= '0;
      stopping          <= 1'b0;
      slot_seen         <= 1'b0;
      coeff_cnt         <= '0;
      coeff_pending     <= 1'b0;
      for (int i = 0; i < NBR_OF_TAPS; i++) begin
        shadow[i] <= '0;
      end
      x_n               <= '0;
      s_axis_fir_tvalid <= 1'b0;
      s_set_coeffs      <= 1'b0;
      y_out             <= '0;
      y_valid           <= 1'b0;
      underrun          <= 1'b0;
    end else begin
      y_valid <= 1'b0;

      if (coeff_wr) begin
        shadow[coeff_cnt] <= host.in_data[TAP_SIZE-1:0];
        if (coeff_cnt == TAP_W'(NBR_OF_TAPS - 1)) begin
          coeff_cnt     <= '0;
          coeff_pending <= 1'b1;
        end else begin
          coeff_cnt <= coeff_cnt + 1'b1;
        end
      end

      case (state)
        S_INIT: begin
          if (init_cnt == INIT_W'(STARTUP_WAIT - 1)) begin
            state <= S_IDLE;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end

        S_IDLE: begin
          if (coeff_pending) begin
            state        <= S_CFG;
            cfg_step     <= '0;
            s_set_coeffs <= 1'b1;
            x_n          <= '0;
          end else if (run && !fifo_empty) begin
            state             <= S_START;
            s_axis_fir_tvalid <= 1'b1;
            x_n               <= '0;
          end
        end

        // C0 strobes with x_n=0; C1..CN present shadow[N-1] down to
        // shadow[0], with the strobe dropped on CN.
        S_CFG: begin
          if (cfg_step == STEP_W'(NBR_OF_TAPS)) begin
            state         <= S_IDLE;
            s_set_coeffs  <= 1'b0;
            x_n           <= '0;
            coeff_pending <= 1'b0;
          end else begin
            cfg_step     <= cfg_step + 1'b1;
            x_n          <= X_N_SIZE'(shadow[cfg_idx]);
            s_set_coeffs <= (cfg_step != STEP_W'(NBR_OF_TAPS - 1));
          end
        end

        S_START: begin
          slot_seen <= 1'b0;
        end

        S_STREAM: begin
          // The FIR result at the end of a p=0 belongs to the previous slot.
          if (phase == '0) begin
            if (slot_seen) begin
              y_out   <= fir_y_n;
              y_valid <= 1'b1;
            end
            slot_seen <= 1'b1;
          end
          if (stopping) begin
            state             <= S_IDLE;
            stopping          <= 1'b0;
            s_axis_fir_tvalid <= 1'b0;
            x_n               <= '0;
          end else begin
            phase <= phase + 1'b1;
          end
        end

        default: state <= S_INIT;
      endcase

      // Entry into the next p=0, from START or the last phase of a slot.
      if (slot_edge) begin
        state             <= S_STREAM;
        phase             <= '0;
        stopping          <= stop_now;
        s_axis_fir_tvalid <= !stop_now;
        x_n               <= slot_x;
        if (!stop_now && fifo_empty) begin
          underrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_driver.sv
// -----------------------------------------------------------------------------
// tb_fir_driver
//   Self-checking bench for fir_driver. Expected values come from slot-level
//   arithmetic: a stream started at cycle T puts sample k on x_n for cycles
//   T+2+6k .. T+7+6k, the stop slot follows the last slot, and each result is
//   the stub value seen during the next p=0. The fir_y_n stub is
//   0x100 + cycle count, so every captured value pins the capture cycle.
// -----------------------------------------------------------------------------
module tb_fir_driver;

  localparam int XW = 8;
  localparam int YW = 11;
  localparam int SL = 6;
  localparam int FD = 4;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          run   = 1'b0;
  logic [XW-1:0] x_n;
  logic          tvalid;
  logic          set_c;
  logic [YW-1:0] fir_y_n;
  logic [YW-1:0] y_out;
  logic          y_valid;
  logic          underrun;

  fir_driver_if #(.X_N_SIZE(XW)) host_if ();

  fir_driver dut (
    .clk               (clk),
    .reset             (reset),
    .host              (host_if),
    .run               (run),
    .x_n               (x_n),
    .s_axis_fir_tvalid (tvalid),
    .s_set_coeffs      (set_c),
    .fir_y_n           (fir_y_n),
    .y_out             (y_out),
    .y_valid           (y_valid),
    .underrun          (underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  assign fir_y_n = YW'(cyc + 256);

  int            n_checks     = 0;
  int            n_fail       = 0;
  logic          exp_underrun = 1'b0;
  logic [XW-1:0] smp [0:7];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic host_write(input logic [XW-1:0] d, input logic is_c, input string tag);
    check({tag, "_in_ready"}, 32'(host_if.in_ready), 32'd1);
    host_if.in_data     = d;
    host_if.in_is_coeff = is_c;
    host_if.in_valid    = 1'b1;
    tick();
    host_if.in_valid    = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x_n"},      32'(x_n),              32'd0);
    check({tag, "_tvalid"},   32'(tvalid),           32'd0);
    check({tag, "_set"},      32'(set_c),            32'd0);
    check({tag, "_y_out"},    32'(y_out),            32'd0);
    check({tag, "_y_valid"},  32'(y_valid),          32'd0);
    check({tag, "_underrun"}, 32'(underrun),         32'd0);
    check({tag, "_in_ready"}, 32'(host_if.in_ready), 32'd0);
  endtask

  // Called at the first cycle after reset is lowered (INIT cycle 1).
  task automatic reset_release();
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      check("init_in_ready", 32'(host_if.in_ready), 32'd0);
      check("init_tvalid",   32'(tvalid),           32'd0);
      check("init_set",      32'(set_c),            32'd0);
      if (i < 5) tick();
    end
    tick();
    check("ready_cycle6", 32'(host_if.in_ready), 32'd1);
  endtask

  // Three coefficient words (a -> tap 0) then the CFG sequence cycle by cycle.
  task automatic load_coeffs(input logic [XW-1:0] a, input logic [XW-1:0] b, input logic [XW-1:0] c);
    logic [XW-1:0] w [0:2];
    logic [XW-1:0] ex;
    w[0] = a; w[1] = b; w[2] = c;
    for (int i = 0; i < 3; i++) host_write(w[i], 1'b1, "coeff");
    check("cfg_pend_ready", 32'(host_if.in_ready), 32'd0);
    check("cfg_pend_set",   32'(set_c),            32'd0);
    for (int k = 0; k <= 4; k++) begin
      tick();
      if (k == 0 || k == 4) ex = '0;
      else begin
        ex = w[3 - k];
        ex = XW'(ex[2:0]);
      end
      check("cfg_set",      32'(set_c),            32'((k < 3) ? 1 : 0));
      check("cfg_x_n",      32'(x_n),              32'(ex));
      check("cfg_tvalid",   32'(tvalid),           32'd0);
      check("cfg_in_ready", 32'(host_if.in_ready), 32'((k == 4) ? 1 : 0));
    end
  endtask

  // n queued samples, u underrun slots, then run drops and the stream stops.
  task automatic stream(input int n, input int u, input bit run_already);
    int            s, t0, k, cnt;
    logic          etv, ev;
    logic [XW-1:0] ex, hold_val;
    s = n + u;
`ifdef FIR_DRV_UNDERRUN_HOLD_EN
    hold_val = smp[n-1];
`else
    hold_val = '0;
`endif
    for (int i = 0; i < n; i++) host_write(smp[i], 1'b0, "push");
    if (!run_already) run = 1'b1;
    t0 = cyc;
    for (int r = 1; r <= 3 + SL * s; r++) begin
      tick();
      if (r == 1) begin
        etv = 1'b1; ex = '0;
      end else if (r < 2 + SL * s) begin
        k   = (r - 2) / SL;
        etv = 1'b1;
        ex  = (k < n) ? smp[k] : hold_val;
      end else begin
        etv = 1'b0; ex = '0;
      end
      if (u > 0 && r >= 2 + SL * n) exp_underrun = 1'b1;
      ev = (r >= 3 + SL) && (r <= 3 + SL * s) && ((r - 3) % SL == 0);
      check("st_tvalid",   32'(tvalid),   32'(etv));
      check("st_x_n",      32'(x_n),      32'(ex));
      check("st_set",      32'(set_c),    32'd0);
      check("st_underrun", 32'(underrun), 32'(exp_underrun));
      check("st_y_valid",  32'(y_valid),  32'(ev));
      if (ev) check("st_y_out", 32'(y_out), 32'(YW'(256 + t0 + r - 1)));
      if (!run_already) begin
        if (r < 2) cnt = n;
        else begin
          k = (r - 2) / SL + 1;
          if (k > n) k = n;
          cnt = n - k;
        end
        check("st_in_ready", 32'(host_if.in_ready), 32'((cnt < FD) ? 1 : 0));
      end
      if (r == SL * s) run = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int            t0, n, u;
    logic [XW-1:0] s0, s1, c0, c1, c2;
    host_if.in_data     = '0;
    host_if.in_is_coeff = 1'b0;
    host_if.in_valid    = 1'b0;

    // Reset and startup wait
    tick(); tick();
    check_all_zero("reset");
    reset_release();

    // Coefficient load 5,2,3
    load_coeffs(8'd5, 8'd2, 8'd3);

    // Basic stream 10,20,30
    smp[0] = 8'd10; smp[1] = 8'd20; smp[2] = 8'd30;
    stream(3, 0, 1'b0);

    // FIFO fills to depth; pop frees a slot one cycle later
    for (int i = 0; i < 4; i++) smp[i] = XW'($urandom);
    stream(4, 0, 1'b0);

    // Single sample followed by an underrun slot
    smp[0] = 8'hA5;
    stream(1, 1, 1'b0);

    // Randomized streams and coefficient loads (upper host bits ignored)
    for (int it = 0; it < 4; it++) begin
      n = int'($urandom_range(1, 4));
      u = int'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) smp[i] = XW'($urandom);
      stream(n, u, 1'b0);
      load_coeffs(XW'($urandom), XW'($urandom), XW'($urandom));
    end

    // Coefficient write while two samples are queued
    s0 = XW'($urandom); s1 = XW'($urandom);
    c0 = XW'($urandom); c1 = XW'($urandom); c2 = XW'($urandom);
    host_write(s0, 1'b0, "mid_push");
    host_write(s1, 1'b0, "mid_push");
    run = 1'b1;
    t0  = cyc;
    tick_to(t0 + 3);
    host_write(c0, 1'b1, "mid_coeff");
    host_write(c1, 1'b1, "mid_coeff");
    host_write(c2, 1'b1, "mid_coeff");
    tick_to(t0 + 8);
    check("mid_x_s1",      32'(x_n),    32'(s1));
    check("mid_tvalid_s1", 32'(tvalid), 32'd1);
    tick_to(t0 + 9);
    check("mid_y_valid0",  32'(y_valid), 32'd1);
    check("mid_y_out0",    32'(y_out),   32'(YW'(256 + t0 + 8)));
    tick_to(t0 + 14);
    check("mid_stop_tv",   32'(tvalid),   32'd0);
    check("mid_stop_x",    32'(x_n),      32'd0);
    check("mid_underrun",  32'(underrun), 32'(exp_underrun));
    tick_to(t0 + 15);
    check("mid_y_valid1",  32'(y_valid), 32'd1);
    check("mid_y_out1",    32'(y_out),   32'(YW'(256 + t0 + 14)));
    check("mid_idle_set",  32'(set_c),   32'd0);
    tick_to(t0 + 16);
    check("mid_c0_set",    32'(set_c),            32'd1);
    check("mid_c0_ready",  32'(host_if.in_ready), 32'd0);
    tick_to(t0 + 17);
    check("mid_c1_set",    32'(set_c), 32'd1);
    check("mid_c1_x",      32'(x_n),   32'(c2[2:0]));
    tick_to(t0 + 18);
    check("mid_c2_set",    32'(set_c), 32'd1);
    check("mid_c2_x",      32'(x_n),   32'(c1[2:0]));
    tick_to(t0 + 19);
    check("mid_c3_set",    32'(set_c),            32'd0);
    check("mid_c3_x",      32'(x_n),              32'(c0[2:0]));
    check("mid_c3_ready",  32'(host_if.in_ready), 32'd0);
    tick_to(t0 + 20);
    check("mid_ret_ready", 32'(host_if.in_ready), 32'd1);
    check("mid_ret_tv",    32'(tvalid),           32'd0);
    // run is still high: the next pushed sample restarts streaming
    smp[0] = XW'($urandom);
    stream(1, 0, 1'b1);

    // Asynchronous reset at p=3 of the first slot
    smp[0] = XW'($urandom); smp[1] = XW'($urandom);
    host_write(smp[0], 1'b0, "rst_push");
    host_write(smp[1], 1'b0, "rst_push");
    run = 1'b1;
    t0  = cyc;
    tick_to(t0 + 5);
    check("rst_pre_x",        32'(x_n),      32'(smp[0]));
    check("rst_pre_tvalid",   32'(tvalid),   32'd1);
    check("rst_pre_underrun", 32'(underrun), 32'(exp_underrun));
    reset = 1'b1;
    #1;
    check_all_zero("rst_async");
    exp_underrun = 1'b0;
    tick(); tick();
    reset_release();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_empty_tv", 32'(tvalid), 32'd0);
    end
    smp[0] = XW'($urandom);
    stream(1, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
